// File: rtl/mux_share_arbiter_pkg.sv
// mux_arb_pkg: FSM state encodings and a width helper for the shared-mux arbiter.
package mux_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/mux_share_arbiter_mux2_bus.sv
// mux2_bus: WIDTH-wide 2:1 select (sel=0 -> a, sel=1 -> b).
module mux2_bus #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin owner of a shared 2:1 path with capped bursts and valid/ready output.
module mux_share_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int CW = clog2(MAX_BURST + 1);
  state_t          r_state, w_next;
  logic            r_last, w_next_last;
  logic [CW-1:0]   r_cnt, w_next_cnt;
  logic            w_own1, w_req_own, w_req_oth, w_beat, w_cap;
  state_t          w_oth_st;
  logic [WIDTH-1:0] w_mux;
  assign gnt0      = r_state == ST_OWN0;
  assign gnt1      = r_state == ST_OWN1;
  assign sel       = gnt1;
  assign busy      = r_state != ST_IDLE;
  assign w_own1    = gnt1;
  assign w_req_own = w_own1 ? req1 : req0;
  assign w_req_oth = w_own1 ? req0 : req1;
  assign w_oth_st  = w_own1 ? ST_OWN0 : ST_OWN1;
  assign out_valid = busy & w_req_own;
  assign w_beat    = out_valid & out_ready;
  assign w_cap     = r_cnt == CW'(MAX_BURST - 1);
  mux2_bus #(.WIDTH(WIDTH)) u_mux (
    .sel(sel),
    .a  (d0),
    .b  (d1),
    .y  (w_mux)
  );
  assign out_data = out_valid ? w_mux : '0;
  // cnt only moves on accepted beats; any ownership change restarts it
  always_comb begin
    w_next      = r_state;
    w_next_last = r_last;
    w_next_cnt  = r_cnt;
    if (r_state == ST_IDLE)
      w_next = (req0 & req1) ? (r_last ? ST_OWN0 : ST_OWN1) : req0 ? ST_OWN0 : req1 ? ST_OWN1 : ST_IDLE;
    else if (!w_req_own) begin
      w_next      = w_req_oth ? w_oth_st : ST_IDLE;
      w_next_last = w_own1;
      w_next_cnt  = '0;
    end else if (w_beat) begin
      w_next_cnt = w_cap ? '0 : r_cnt + CW'(1);
      if (w_cap & w_req_oth) begin
        w_next      = w_oth_st;
        w_next_last = w_own1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_last  <= w_next_last;
      r_cnt   <= w_next_cnt;
    end
  end
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed-vector bench for mux_share_arbiter.
module tb_mux_share_arbiter;
  logic       clk = 0;
  logic       rst_n, req0, req1, out_ready;
  logic [3:0] d0, d1, out_data;
  logic       gnt0, gnt1, sel, out_valid, busy;
  logic [4:0] st;
  int         checks = 0;
  int         fails = 0;
  mux_share_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .d0       (d0),
    .d1       (d1),
    .out_ready(out_ready),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  assign st = {gnt0, gnt1, sel, out_valid, busy};
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; req0 = 0; req1 = 0; d0 = 0; d1 = 0; out_ready = 0;
    tick; tick;
    check("rst_st", st, 5'b00000);
    check("rst_data", out_data, 0);
    rst_n = 1; req0 = 1; d0 = 4'h5; out_ready = 1; #1;
    check("lone_pre", st, 5'b00000);
    tick;
    check("lone_st", st, 5'b10011);
    check("lone_data", out_data, 4'h5);
    rst_n = 0; req0 = 0;
    tick; tick;
    rst_n = 1; req0 = 1; req1 = 1; d0 = 4'h3; d1 = 4'hA;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("cont_own0", st, 5'b10011);
      check("cont_d0", out_data, 4'h3);
      tick;
    end
    check("cont_hand", st, 5'b01111);
    check("cont_d1", out_data, 4'hA);
    tick;
    out_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_st", st, 5'b01111);
      check("stall_data", out_data, 4'hA);
      tick;
    end
    out_ready = 1;
    tick;
    check("stall_cnt2", st, 5'b01111);
    tick;
    check("stall_cnt3", st, 5'b01111);
    tick;
    check("stall_hand", st, 5'b10011);
    check("stall_hand_d", out_data, 4'h3);
    req0 = 0; #1;
    check("drop_st", st, 5'b10001);
    check("drop_data", out_data, 0);
    tick;
    for (int i = 0; i < 10; i++) begin
      check("solo_st", st, 5'b01111);
      tick;
    end
    req0 = 1; #1;
    check("wrap_cnt2", st, 5'b01111);
    tick;
    check("wrap_cnt3", st, 5'b01111);
    tick;
    check("wrap_hand", st, 5'b10011);
    req1 = 0;
    tick; tick;
    check("mid_own0", st, 5'b10011);
    rst_n = 0; req1 = 1;
    tick;
    rst_n = 1; #1;
    check("mid_rst_st", st, 5'b00000);
    check("mid_rst_data", out_data, 0);
    tick;
    check("mid_after", st, 5'b10011);
    check("mid_after_d", out_data, 4'h3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
